// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main controller for the multicycle RV32I core.
// Sequences ALU, unified memory and regfile; stall, halt, retire count.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALU_Op,
    output logic             RegWrite,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_o
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             w_retire;
    logic             w_pcupdate;
    logic             w_branch;

    // next-state selection, stalls hold the current state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_FETCH;
        endcase
    end

    // an instruction retires on its last cycle
    always_comb begin
        w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                   (r_state == S_BEQ) ||
                   ((r_state == S_MEMWRITE) && mem_ready);
    end

    // datapath controls decoded from state, forced low while in reset
    always_comb begin
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALU_Op     = 2'b00;
        RegWrite   = 1'b0;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        if (!RST) begin
            unique case (r_state)
                S_FETCH: begin
                    ALUSrcB    = 2'b10;
                    ResultSrc  = 2'b10;
                    IRWrite    = mem_ready;
                    w_pcupdate = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALU_Op  = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALU_Op  = 2'b10;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA  = 2'b10;
                    ALU_Op   = 2'b01;
                    w_branch = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    w_pcupdate = 1'b1;
                end
                default: ;
            endcase
        end
        PCWrite = w_pcupdate | (w_branch & Zero);
    end

    // state, sticky illegal flag and retire counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + 1'b1;
            if ((r_state == S_DECODE) && (w_next == S_HALT))
                r_illegal <= 1'b1;
        end
    end

    assign illegal_instr = r_illegal;
    assign instr_count   = r_count;
    assign state_o       = r_state;
endmodule
